trivium_stream_decrypt: RTL and testbench

// - Receive-side Trivium unit: loads an 80-bit key and IV, runs the 1152-round warm-up,

---
 rtl/trivium_pkg.sv | 55 +++++
 rtl/trivium_round_unroll.sv | 50 +++++
 rtl/trivium_stream_decrypt.sv | 124 ++++++++++++
 tb/tb_trivium_stream_decrypt.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// -----------------------------------------------------------------------------
// trivium_pkg
// Shared constants and types for the Trivium stream-cipher blocks.
//   - Key / IV / state widths and the default warm-up length.
//   - FSM state encoding for the stream unit.
//   - 0-based tap positions: Trivium bit s_k is stored at vector index k-1.
//   - load_state(): builds the initial 288-bit state from key and IV.
// -----------------------------------------------------------------------------
package trivium_pkg;

    localparam int KEY_W               = 80;
    localparam int IV_W                = 80;
    localparam int STATE_W             = 288;
    localparam int INIT_ROUNDS_DEFAULT = 1152;  // 4 full passes over the 288-bit state

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Register heads: the IV lands at s94, i.e. the head of the second register.
    localparam int IV_BASE   = 93;

    // Linear taps of each register (s66/s93, s162/s177, s243/s288).
    localparam int T1_A      = 65;
    localparam int T1_B      = 92;
    localparam int T2_A      = 161;
    localparam int T2_B      = 176;
    localparam int T3_A      = 242;
    localparam int T3_B      = 287;

    // AND-pair and cross-feed taps (s91&s92 ^ s171, s175&s176 ^ s264, s286&s287 ^ s69).
    localparam int T1_AND_A  = 90;
    localparam int T1_AND_B  = 91;
    localparam int T1_FB     = 170;
    localparam int T2_AND_A  = 174;
    localparam int T2_AND_B  = 175;
    localparam int T2_FB     = 263;
    localparam int T3_AND_A  = 285;
    localparam int T3_AND_B  = 286;
    localparam int T3_FB     = 68;

    // s1..s80 = key, s94..s173 = iv, s286..s288 = 1, everything else 0.
    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        logic [STATE_W-1:0] s;
        s                     = '0;
        s[KEY_W-1:0]          = key;
        s[IV_BASE +: IV_W]    = iv;
        s[STATE_W-1 -: 3]     = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round_unroll.sv
// -----------------------------------------------------------------------------
// trivium_round_unroll
// Purely combinational: advances the Trivium state by W rounds and returns the
// W keystream bits produced on the way (bit j = keystream of round j, taken
// before that round's shift).
// Ports:
//   i_state  in   288  current state, s_k at index k-1
//   o_state  out  288  state after W rounds
//   o_ks     out  W    keystream word, LSB = first round
// -----------------------------------------------------------------------------
module trivium_round_unroll
    import trivium_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [STATE_W-1:0] i_state,
    output logic [STATE_W-1:0] o_state,
    output logic [W-1:0]       o_ks
);

    logic [STATE_W-1:0] w_s;
    logic               w_t1;
    logic               w_t2;
    logic               w_t3;

    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path can infer a latch.
        w_s   = i_state;
        w_t1  = 1'b0;
        w_t2  = 1'b0;
        w_t3  = 1'b0;
        o_ks  = '0;
        // NOTE: blocking assignments on purpose: each unrolled round must see the
        // state the previous round just produced within the same evaluation.
        for (int j = 0; j < W; j++) begin
            w_t1    = w_s[T1_A] ^ w_s[T1_B];
            w_t2    = w_s[T2_A] ^ w_s[T2_B];
            w_t3    = w_s[T3_A] ^ w_s[T3_B];
            o_ks[j] = w_t1 ^ w_t2 ^ w_t3;
            w_t1    = w_t1 ^ (w_s[T1_AND_A] & w_s[T1_AND_B]) ^ w_s[T1_FB];
            w_t2    = w_t2 ^ (w_s[T2_AND_A] & w_s[T2_AND_B]) ^ w_s[T2_FB];
            w_t3    = w_t3 ^ (w_s[T3_AND_A] & w_s[T3_AND_B]) ^ w_s[T3_FB];
            // Each of the three registers shifts toward its tail; the new bit
            // enters at its head (s1, s94, s178).
            w_s     = {w_s[286:177], w_t2, w_s[175:93], w_t1, w_s[91:0], w_t3};
        end
        o_state = w_s;
    end

endmodule

// File: rtl/trivium_stream_decrypt.sv
// -----------------------------------------------------------------------------
// trivium_stream_decrypt
// Trivium stream unit: loads key/IV on start, runs the warm-up, then XORs W
// keystream bits onto each accepted input beat. Encryption and decryption are
// the same operation.
// Parameters:
//   W            keystream bits per beat (1..64, must divide INIT_ROUNDS)
//   INIT_ROUNDS  warm-up rounds before the first keystream bit
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   key, iv        in    80-bit key / IV, sampled when start is high
//   start          in    (re)load key/IV and begin warm-up, from any state
//   init_done      out   high while keystream is available
//   in_valid/in_ready    input handshake; in_data (W), in_last
//   out_valid/out_ready  output handshake; out_data (W), out_last
// -----------------------------------------------------------------------------
module trivium_stream_decrypt
    import trivium_pkg::*;
#(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = trivium_pkg::INIT_ROUNDS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    input  logic             start,
    output logic             init_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last
);

    localparam int               INIT_CYCLES = INIT_ROUNDS / W;
    localparam int               CNT_W       = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(INIT_CYCLES);

    state_e             r_fsm;
    logic [CNT_W-1:0]   r_cnt;
    logic [STATE_W-1:0] r_state;
    logic               r_out_valid;
    logic [W-1:0]       r_out_data;
    logic               r_out_last;

    logic [STATE_W-1:0] w_next_state;
    logic [W-1:0]       w_ks;
    logic               w_accept;

    trivium_round_unroll #(
        .W (W)
    ) u_rounds (
        .i_state (r_state),
        .o_state (w_next_state),
        .o_ks    (w_ks)
    );

    // A beat arriving together with start belongs to the old key: refuse it.
    assign in_ready  = (r_fsm == RUN) && !start && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign init_done = (r_fsm == RUN);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // Cipher state and sequencing. The counter runs 0..INIT_CYCLES: the first
    // INIT_CYCLES cycles each advance W rounds, the last one only moves to RUN,
    // so init_done rises INIT_CYCLES+1 edges after the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_cnt   <= '0;
            // NOTE: the 288-bit state is ordinary flops, not a RAM, so it takes
            // the async reset like every other register here.
            r_state <= '0;
        end else if (start) begin
            r_fsm   <= INIT;
            r_cnt   <= '0;
            r_state <= load_state(key, iv);
        end else begin
            case (r_fsm)
                IDLE: ;
                INIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_fsm <= RUN;
                    end else begin
                        r_state <= w_next_state;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    // Keystream advances only with a consumed beat: never skipped, never reused.
                    if (w_accept) begin
                        r_state <= w_next_state;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    // Single output register slice; holds data stable while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (start) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data ^ w_ks;
            r_out_last  <= in_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// -----------------------------------------------------------------------------
// tb_trivium_stream_decrypt
// Self-checking bench for trivium_stream_decrypt (W=8 main instance plus W=1
// and W=64 instances for the width sweep). Expected keystream comes from an
// independent bit-serial Trivium model kept as three separate registers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trivium_stream_decrypt;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [79:0]  key;
    logic [79:0]  iv;
    logic         start;
    logic         init_done;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    // Width-sweep instances: always offered zero data, always drained.
    logic [79:0]  sw_key;
    logic [79:0]  sw_iv;
    logic         sw_start;
    logic         sw1_init_done,  sw1_in_ready,  sw1_out_valid,  sw1_out_last;
    logic [0:0]   sw1_out_data;
    logic         sw64_init_done, sw64_in_ready, sw64_out_valid, sw64_out_last;
    logic [63:0]  sw64_out_data;

    always #5 clk = ~clk;

    trivium_stream_decrypt #(.W(8), .INIT_ROUNDS(1152)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .start(start),
        .init_done(init_done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    trivium_stream_decrypt #(.W(1), .INIT_ROUNDS(1152)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .key(sw_key), .iv(sw_iv), .start(sw_start),
        .init_done(sw1_init_done), .in_valid(1'b1), .in_ready(sw1_in_ready),
        .in_data(1'b0), .in_last(1'b0), .out_valid(sw1_out_valid),
        .out_ready(1'b1), .out_data(sw1_out_data), .out_last(sw1_out_last)
    );

    trivium_stream_decrypt #(.W(64), .INIT_ROUNDS(1152)) dut_w64 (
        .clk(clk), .rst_n(rst_n), .key(sw_key), .iv(sw_iv), .start(sw_start),
        .init_done(sw64_init_done), .in_valid(1'b1), .in_ready(sw64_in_ready),
        .in_data(64'd0), .in_last(1'b0), .out_valid(sw64_out_valid),
        .out_ready(1'b1), .out_data(sw64_out_data), .out_last(sw64_out_last)
    );

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------- model
    // Trivium as in the reference description: A = s1..s93, B = s94..s177, C = s178..s288.
    logic [1:93]  ma;
    logic [1:84]  mb;
    logic [1:111] mc;

    task automatic m_step(output logic z);
        logic t1, t2, t3;
        t1 = ma[66] ^ ma[93];
        t2 = mb[69] ^ mb[84];
        t3 = mc[66] ^ mc[111];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ma[91] & ma[92]) ^ mb[78];
        t2 = t2 ^ (mb[82] & mb[83]) ^ mc[87];
        t3 = t3 ^ (mc[109] & mc[110]) ^ ma[69];
        ma = {t3, ma[1:92]};
        mb = {t1, mb[1:83]};
        mc = {t2, mc[1:110]};
    endtask

    task automatic m_load(input logic [79:0] k, input logic [79:0] v);
        logic dummy;
        ma = '0;
        mb = '0;
        mc = '0;
        for (int i = 0; i < 80; i++) begin
            ma[i+1] = k[i];
            mb[i+1] = v[i];
        end
        mc[109] = 1'b1;
        mc[110] = 1'b1;
        mc[111] = 1'b1;
        for (int i = 0; i < 1152; i++) m_step(dummy);
    endtask

    task automatic m_byte(output logic [7:0] b);
        logic z;
        for (int j = 0; j < 8; j++) begin
            m_step(z);
            b[j] = z;
        end
    endtask

    // --------------------------------------------------------------- stimulus
    logic [7:0] tx_data [256];
    logic       tx_last [256];
    logic [7:0] rx_data [256];
    logic       rx_last [256];
    logic [7:0] ct      [256];
    int         rx_n;

    // All tasks start and end 1 ns after a rising edge.
    task automatic do_start(input logic [79:0] k, input logic [79:0] v);
        key   = k;
        iv    = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_init(output int lat);
        lat = 0;
        while (!init_done && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Push n beats from tx_* and collect n beats into rx_*, with random
    // in_valid / out_ready duty cycles (percent). Checks output stability on stalls.
    task automatic run_stream(input int n, input int vpct, input int rpct,
                              input string tag, output int cyc);
        int         sent;
        logic       stalled;
        logic [7:0] held;
        sent    = 0;
        rx_n    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (rx_n < n && cyc < 4000) begin
            if (sent < n && $urandom_range(0, 99) < vpct) begin
                in_valid = 1'b1;
                in_data  = tx_data[sent];
                in_last  = tx_last[sent];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom());
                in_last  = 1'($urandom());
            end
            out_ready = ($urandom_range(0, 99) < rpct);
            #1;
            if (stalled) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_data"}, out_data, held);
            end
            if (out_valid && out_ready) begin
                rx_data[rx_n] = out_data;
                rx_last[rx_n] = out_last;
                rx_n++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_beats"}, rx_n, n);
    endtask

    // Model must be loaded (and warmed up) for the stream's key/iv beforehand.
    task automatic expect_stream(input int n, input string tag);
        logic [7:0] ks;
        for (int i = 0; i < n; i++) begin
            m_byte(ks);
            check($sformatf("%s_data%0d", tag, i), rx_data[i], tx_data[i] ^ ks);
            check($sformatf("%s_last%0d", tag, i), rx_last[i], tx_last[i]);
        end
    endtask

    localparam logic [79:0] K_RT  = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] IV_RT = 80'hFEDCBA9876543210FEDC;
    localparam logic [79:0] K_BP  = 80'h5A5A1234C3C39876F00F;
    localparam logic [79:0] IV_BP = 80'h0F1E2D3C4B5A69788796;
    localparam logic [79:0] K_A   = 80'h11112222333344445555;
    localparam logic [79:0] IV_A  = 80'hAAAABBBBCCCCDDDDEEEE;
    localparam logic [79:0] K_B   = 80'h00000000000000000001;
    localparam logic [79:0] IV_B  = 80'h80000000000000000000;
    localparam logic [79:0] K_C   = 80'hDEADBEEFCAFEF00D1234;
    localparam logic [79:0] IV_C  = 80'h13579BDF02468ACE1357;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, cyc, seen, lat1, lat64, n1, n64;
        logic       bits1 [128];
        logic [63:0] w64  [2];
        logic       z;

        rst_n = 1'b0; start = 1'b0; key = '0; iv = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        sw_key = '0; sw_iv = '0; sw_start = 1'b0;

        // ---- reset state
        repeat (3) @(posedge clk); #1;
        check("rst_init_done", init_done, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_last",  out_last,  0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("idle_in_ready",  in_ready,  0);
        check("idle_init_done", init_done, 0);

        // ---- all-zero key/iv: init latency, raw keystream z(0..63), full throughput
        do_start('0, '0);
        wait_init(lat);
        check("zero_init_lat", lat, 145);
        for (int i = 0; i < 8; i++) begin
            tx_data[i] = 8'h00;
            tx_last[i] = (i == 7);
        end
        run_stream(8, 100, 100, "zero", cyc);
        check("zero_cycles", cyc, 9);
        m_load('0, '0);
        expect_stream(8, "zero");

        // ---- backpressure with random data and random last bits
        do_start(K_BP, IV_BP);
        wait_init(lat);
        check("bp_init_lat", lat, 145);
        for (int i = 0; i < 200; i++) begin
            tx_data[i] = 8'($urandom());
            tx_last[i] = 1'($urandom());
        end
        run_stream(200, 70, 30, "bp", cyc);
        m_load(K_BP, IV_BP);
        expect_stream(200, "bp");

        // ---- round trip: encrypt 256 x 0xA5, restart, decrypt
        for (int i = 0; i < 256; i++) begin
            tx_data[i] = 8'hA5;
            tx_last[i] = (i == 255);
        end
        do_start(K_RT, IV_RT);
        wait_init(lat);
        run_stream(256, 100, 100, "rt_enc", cyc);
        m_load(K_RT, IV_RT);
        expect_stream(256, "rt_enc");
        for (int i = 0; i < 256; i++) ct[i] = rx_data[i];
        for (int i = 0; i < 256; i++) tx_data[i] = ct[i];
        do_start(K_RT, IV_RT);
        wait_init(lat);
        check("rt_init_lat", lat, 145);
        run_stream(256, 80, 60, "rt_dec", cyc);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("rt_pt%0d", i), rx_data[i], 8'hA5);
            check($sformatf("rt_last%0d", i), rx_last[i], (i == 255));
        end

        // ---- restart at INIT cycle 70
        do_start(K_A, IV_A);
        repeat (70) @(posedge clk); #1;
        check("init70_not_done", init_done, 0);
        do_start(K_B, IV_B);
        wait_init(lat);
        check("restart_init_lat", lat, 145);
        tx_data[0] = 8'h00;
        tx_last[0] = 1'b0;
        run_stream(1, 100, 100, "restart_init", cyc);
        m_load(K_B, IV_B);
        expect_stream(1, "restart_init");

        // ---- restart in RUN with a pending output beat and a simultaneous input beat
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        in_last   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("pend_valid", out_valid, 1);
        key      = K_C;
        iv       = IV_C;
        start    = 1'b1;
        in_data  = 8'h55;
        #1;
        check("start_blocks_in_ready", in_ready, 0);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_drops_beat", out_valid, 0);
        check("start_clears_init_done", init_done, 0);
        wait_init(lat);
        check("restart_run_lat", lat, 145);
        tx_data[0] = 8'h00;
        tx_last[0] = 1'b1;
        run_stream(1, 100, 100, "restart_run", cyc);
        m_load(K_C, IV_C);
        expect_stream(1, "restart_run");

        // ---- async reset mid-RUN with a pending beat; start during reset ignored
        in_valid  = 1'b1;
        in_data   = 8'h11;
        in_last   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rr_pend_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_out_valid", out_valid, 0);
        check("rr_out_data",  out_data,  0);
        check("rr_out_last",  out_last,  0);
        check("rr_init_done", init_done, 0);
        check("rr_in_ready",  in_ready,  0);
        key   = K_RT;
        iv    = IV_RT;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (init_done || in_ready) seen++;
        end
        check("rr_stays_idle", seen, 0);

        // ---- width sweep: W=1 and W=64 against the same model bitstream
        sw_key   = K_RT;
        sw_iv    = IV_RT;
        sw_start = 1'b1;
        @(posedge clk); #1;
        sw_start = 1'b0;
        lat1 = -1; lat64 = -1; n1 = 0; n64 = 0; cyc = 0;
        while ((n1 < 128 || n64 < 2) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (lat1 < 0 && sw1_init_done)   lat1  = cyc;
            if (lat64 < 0 && sw64_init_done) lat64 = cyc;
            if (sw1_out_valid && n1 < 128) begin
                bits1[n1] = sw1_out_data[0];
                n1++;
            end
            if (sw64_out_valid && n64 < 2) begin
                w64[n64] = sw64_out_data;
                n64++;
            end
        end
        check("sw_w1_init_lat",  lat1,  1153);
        check("sw_w64_init_lat", lat64, 19);
        check("sw_w1_beats",  n1,  128);
        check("sw_w64_beats", n64, 2);
        m_load(K_RT, IV_RT);
        for (int i = 0; i < 128; i++) begin
            m_step(z);
            check($sformatf("sw_w1_bit%0d", i), bits1[i], z);
            check($sformatf("sw_w64_bit%0d", i), w64[i / 64][i % 64], z);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
